compress_handler: RTL
=====================

// Module: compress_handler
// PURPOSE
//  Run-length encoder. Reads a bit-packed byte region from RAM (MSB first within each byte)
//  and emits one 8-bit code per run: code[7] = bit value, code[6:0] = run length (1..MAX_RUN).
//  Runs longer than MAX_RUN are split into several codes.
//  Sits between the RAM/DMA port and the compressed-stream consumer.
//  Its code stream is the input format that decompress_handler consumes.
// PARAMETERS
//  ADDR_W   16   RAM address width
//  LEN_W    16   width of byteCount and codeCount
//  MAX_RUN  127  longest run per code; legal range 1..127
// PORTS
//  clk            in   1       clock; all logic on posedge
//  RST            in   1       synchronous, active-high reset
//  start          in   1       1-cycle pulse; sampled only in IDLE
//  baseAddress    in   ADDR_W  first RAM byte to encode; latched on start
//  byteCount      in   LEN_W   number of bytes to encode; latched on start
//  ramAddress     out  ADDR_W  RAM read address
//  ramReadSignal  out  1       RAM read strobe
//  ramDataIn      in   8       RAM read data; valid 1 cycle after ramReadSignal
//  codeOut        out  8       RLE code {bit, len}
//  codeValid      out  1       codeOut is valid
//  codeReady      in   1       consumer accepts the code
//  busy           out  1       high from the cycle after start until done
//  done           out  1       1-cycle pulse when the job completes
//  codeCount      out  LEN_W   codes emitted in the current/last job; cleared on start
// BEHAVIOUR
//  Reset: all outputs are 0; the FSM enters IDLE; run state is cleared.
//   RST asserted mid-job aborts the job; no done pulse is produced.
//  FSM states:
//   IDLE  -> FETCH on start with byteCount != 0.
//   IDLE  -> DONE  on start with byteCount == 0; no RAM read, no code.
//   FETCH drives ramReadSignal = 1 and ramAddress = base + byteIdx for 1 cycle, then goes to WAIT.
//   WAIT captures ramDataIn into the shift register, sets bitIdx = 7, then goes to SCAN.
//   SCAN processes one bit per cycle, MSB first:
//    - First bit of the job: curBit = bit, runLen = 1.
//    - bit == curBit && runLen < MAX_RUN: runLen++.
//    - Otherwise: load codeOut = {curBit, runLen[6:0]}, go to EMIT, and hold the pending bit.
//      After EMIT, the new run starts with curBit = bit, runLen = 1.
//    - After bit 0: if more bytes remain, byteIdx++ and go to FETCH.
//      If this was the last byte, go to FLUSH.
//   EMIT holds codeValid = 1 with codeOut stable until codeReady = 1.
//    On that cycle the code transfers, codeCount++, and the FSM resumes SCAN.
//    Scanning stalls while codeValid = 1 && codeReady = 0.
//   FLUSH emits the final run with the same handshake as EMIT, then goes to DONE.
//   DONE pulses done = 1 and clears busy in the same cycle, then goes to IDLE.
//  Handshake rules:
//   codeValid never drops without a transfer.
//   codeReady is ignored while codeValid = 0.
//  Simultaneous events: start while busy is ignored; RST has priority over start.
//  Arithmetic:
//   ramAddress = baseAddress + byteIdx, modulo 2^ADDR_W (wraps without error).
//   codeCount saturates at all-ones.
//  Throughput: 10 cycles per byte (FETCH + WAIT + 8 SCAN), plus 1 or more cycles per emitted code.
// CONFIGURATION
//  Macro COMPRESS_HANDLER_STATS_EN.
//  Defined: adds output port onesCount, LEN_W+3 bits wide.
//   It counts 1-bits encoded; cleared on start; valid when done pulses.
//  Undefined: the port and its counter do not exist; all other behaviour is identical.
// TESTING
//  T1 RAM[0x10]=0x00, base=0x10, count=1 -> single code 0x08; done; codeCount=1.
//  T2 RAM[0]=0xF0, RAM[1]=0x0F, count=2 -> codes 0x84, 0x08, 0x84; codeCount=3.
//  T3 32 bytes of 0xFF -> codes 0xFF, 0xFF, 0x82 (127+127+2 = 256); codeCount=3.
//     With STATS_EN, onesCount=256.
//  T4 count=0 -> done 1 cycle after busy rises; no ramReadSignal; no codeValid; codeCount=0.
//  T5 T2 with codeReady=0 for 10 cycles at each code -> codeOut held stable; same 3 codes; no extra RAM reads.
//  T6 RST mid-T3 -> next cycle busy=0, codeValid=0, no done.
//     A following start with base=0xFFFF, count=2 reads 0xFFFF then 0x0000 (wrap).

Source files
------------

// File: rtl/compress_handler.sv
// Run-length encoder: scans a RAM byte region MSB-first and emits {bit, runLen} codes.
// Optional macro COMPRESS_HANDLER_STATS_EN adds the onesCount output.
module compress_handler #(
    parameter int ADDR_W  = 16,
    parameter int LEN_W   = 16,
    parameter int MAX_RUN = 127
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] baseAddress,
    input  logic [LEN_W-1:0]  byteCount,
    output logic [ADDR_W-1:0] ramAddress,
    output logic              ramReadSignal,
    input  logic [7:0]        ramDataIn,
    output logic [7:0]        codeOut,
    output logic              codeValid,
    input  logic              codeReady,
    output logic              busy,
    output logic              done,
`ifdef COMPRESS_HANDLER_STATS_EN
    output logic [LEN_W+2:0]  onesCount,
`endif
    output logic [LEN_W-1:0]  codeCount
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_SCAN, S_EMIT, S_FLUSH, S_DONE
    } state_t;

    localparam logic [6:0] LP_MAX = 7'(MAX_RUN);

    state_t             r_state, w_next;
    logic [ADDR_W-1:0]  r_base;
    logic [LEN_W-1:0]   r_count, r_byteIdx, r_codeCount;
    logic [7:0]         r_shift, r_code;
    logic [3:0]         r_bitCnt;
    logic               r_curBit, r_first, r_busy, r_done;
    logic [6:0]         r_runLen;
`ifdef COMPRESS_HANDLER_STATS_EN
    logic [LEN_W+2:0]   r_ones;
`endif

    logic w_bit, w_more, w_split, w_lastBit;

    assign w_bit     = r_shift[7];
    assign w_more    = (r_byteIdx != r_count - LEN_W'(1));
    // The current bit closes the open run when it differs or the run is full.
    assign w_split   = !r_first && ((w_bit != r_curBit) || (r_runLen == LP_MAX));
    assign w_lastBit = (r_bitCnt == 4'd1);

    assign ramReadSignal = (r_state == S_FETCH);
    assign ramAddress    = (r_state == S_FETCH) ? r_base + ADDR_W'(r_byteIdx) : '0;
    assign codeValid     = (r_state == S_EMIT) || (r_state == S_FLUSH);
    assign codeOut       = r_code;
    assign busy          = r_busy;
    assign done          = r_done;
    assign codeCount     = r_codeCount;
`ifdef COMPRESS_HANDLER_STATS_EN
    assign onesCount     = r_ones;
`endif

    always_ff @(posedge clk) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (byteCount == '0) ? S_DONE : S_FETCH;
            S_FETCH: w_next = S_WAIT;
            S_WAIT:  w_next = S_SCAN;
            S_SCAN: begin
                if (w_split)        w_next = S_EMIT;
                else if (w_lastBit) w_next = w_more ? S_FETCH : S_FLUSH;
            end
            S_EMIT: begin
                if (codeReady) begin
                    if (r_bitCnt == 4'd0) w_next = w_more ? S_FETCH : S_FLUSH;
                    else                  w_next = S_SCAN;
                end
            end
            S_FLUSH: if (codeReady) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_base      <= '0;
            r_count     <= '0;
            r_byteIdx   <= '0;
            r_codeCount <= '0;
            r_shift     <= '0;
            r_code      <= '0;
            r_bitCnt    <= '0;
            r_curBit    <= 1'b0;
            r_runLen    <= '0;
            r_first     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef COMPRESS_HANDLER_STATS_EN
            r_ones      <= '0;
`endif
        end else begin
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base      <= baseAddress;
                        r_count     <= byteCount;
                        r_byteIdx   <= '0;
                        r_first     <= 1'b1;
                        r_codeCount <= '0;
                        r_busy      <= 1'b1;
`ifdef COMPRESS_HANDLER_STATS_EN
                        r_ones      <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    r_shift  <= ramDataIn;
                    r_bitCnt <= 4'd8;
                end
                S_SCAN: begin
                    r_shift  <= {r_shift[6:0], 1'b0};
                    r_bitCnt <= r_bitCnt - 4'd1;
`ifdef COMPRESS_HANDLER_STATS_EN
                    r_ones   <= r_ones + (LEN_W+3)'(w_bit);
`endif
                    // The pending bit is consumed here and opens the next run.
                    if (r_first || w_split) begin
                        r_curBit <= w_bit;
                        r_runLen <= 7'd1;
                        r_first  <= 1'b0;
                    end else begin
                        r_runLen <= r_runLen + 7'd1;
                    end
                    if (w_split)
                        r_code <= {r_curBit, r_runLen};
                    else if (w_lastBit && !w_more)
                        r_code <= {w_bit, r_first ? 7'd1 : r_runLen + 7'd1};
                    if (!w_split && w_lastBit && w_more)
                        r_byteIdx <= r_byteIdx + LEN_W'(1);
                end
                S_EMIT: begin
                    if (codeReady) begin
                        if (r_codeCount != '1) r_codeCount <= r_codeCount + LEN_W'(1);
                        if (r_bitCnt == 4'd0) begin
                            if (w_more) r_byteIdx <= r_byteIdx + LEN_W'(1);
                            else        r_code    <= {r_curBit, r_runLen};
                        end
                    end
                end
                S_FLUSH: begin
                    if (codeReady && r_codeCount != '1) r_codeCount <= r_codeCount + LEN_W'(1);
                end
                S_DONE: r_busy <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
